operand_b_stage: RTL and testbench

Parametrised successor to the 8-bit ALU operand-B selector. It selects the ALU B operand from the register, an immediate (zero- or sign-extended), constant zero, or memory read data. The selected operand is registered behind a two-entry skid buffer with valid/ready handshakes, so the decode and ALU stages can stall independently. It sits between decode/register-read and the ALU B input.

---
 rtl/operand_b_if.sv | 26 ++
 rtl/operand_b_stage.sv | 107 ++++++++++
 tb/tb_operand_b_stage.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/operand_b_if.sv
// Handshake and data bundle between decode/register-read, the operand-B stage and the ALU.
interface operand_b_if #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned IMM_W = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       s;
    logic [WIDTH-1:0] B;
    logic [IMM_W-1:0] Im;
    logic [WIDTH-1:0] mem_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out;
    logic             sel_err;

    modport master (
        output in_valid, s, B, Im, mem_data, out_ready,
        input  in_ready, out_valid, out, sel_err
    );

    modport slave (
        input  in_valid, s, B, Im, mem_data, out_ready,
        output in_ready, out_valid, out, sel_err
    );
endinterface

// File: rtl/operand_b_stage.sv
// ALU operand-B selector with a two-entry skid buffer so decode and ALU can stall independently.
module operand_b_stage #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned IMM_W = 8
) (
    input  logic        clk,
    input  logic        rst,
    operand_b_if.slave  bus
);
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] main_q, main_d;
    logic [WIDTH-1:0] skid_q, skid_d;
    logic             out_valid_q, out_valid_d;
    logic             in_ready_q, in_ready_d;
    logic             sel_err_q, sel_err_d;

    logic [WIDTH-1:0] sel_val_c;
    logic             reserved_c;
    logic             accept_c;
    logic             consume_c;

    // Operand select decode on the presented input
    always_comb begin
        sel_val_c  = bus.B;
        reserved_c = 1'b0;
        case (bus.s)
            3'b000:  sel_val_c = bus.B;
            3'b001:  sel_val_c = WIDTH'(bus.Im);
            3'b010:  sel_val_c = '0;
            3'b011:  sel_val_c = WIDTH'($signed(bus.Im));
            3'b100:  sel_val_c = bus.mem_data;
            default: begin
                sel_val_c  = bus.B;
                reserved_c = 1'b1;
            end
        endcase
    end

    assign accept_c  = bus.in_valid && in_ready_q;
    assign consume_c = out_valid_q && bus.out_ready;

    // Occupancy state machine: main drives the output, skid absorbs one extra operand
    always_comb begin
        state_d   = state_q;
        main_d    = main_q;
        skid_d    = skid_q;
        sel_err_d = sel_err_q || (accept_c && reserved_c);

        case (state_q)
            EMPTY: begin
                if (accept_c) begin
                    main_d  = sel_val_c;
                    state_d = ONE;
                end
            end
            ONE: begin
                if (accept_c && consume_c) begin
                    main_d  = sel_val_c;
                end else if (accept_c) begin
                    skid_d  = sel_val_c;
                    state_d = FULL;
                end else if (consume_c) begin
                    state_d = EMPTY;
                end
            end
            FULL: begin
                if (consume_c) begin
                    main_d  = skid_q;
                    state_d = ONE;
                end
            end
            default: state_d = EMPTY;
        endcase

        out_valid_d = (state_d != EMPTY);
        in_ready_d  = (state_d != FULL);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= EMPTY;
            main_q      <= '0;
            skid_q      <= '0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            sel_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            main_q      <= main_d;
            skid_q      <= skid_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
            sel_err_q   <= sel_err_d;
        end
    end

    assign bus.out       = main_q;
    assign bus.out_valid = out_valid_q;
    assign bus.in_ready  = in_ready_q;
    assign bus.sel_err   = sel_err_q;
endmodule

// File: tb/tb_operand_b_stage.sv
// Scoreboard bench for operand_b_stage (WIDTH=8, IMM_W=4): directed plan items plus randomized traffic.
module tb_operand_b_stage;
    localparam int unsigned W  = 8;
    localparam int unsigned IW = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    operand_b_if #(.WIDTH(W), .IMM_W(IW)) bus ();

    operand_b_stage #(.WIDTH(W), .IMM_W(IW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int compared   = 0;
    int mismatched = 0;

    logic [W-1:0] exp_q[$];
    logic [W-1:0] last_out = '0;
    logic         exp_sel_err = 1'b0;
    bit           armed = 1'b0;
    bit           rand_ready = 1'b0;
    bit           cons_m, acc_m;
    logic [W-1:0] exp_out;

    // Reference: operand value from the select rules, in plain integer arithmetic
    function automatic logic [W-1:0] ref_sel(input logic [2:0] s, input logic [W-1:0] b,
                                             input logic [IW-1:0] im, input logic [W-1:0] md);
        int v;
        case (s)
            3'd0:    v = int'(b);
            3'd1:    v = int'(im);
            3'd2:    v = 0;
            3'd3:    v = (int'(im) >= (1 << (IW - 1))) ? int'(im) - (1 << IW) : int'(im);
            3'd4:    v = int'(md);
            default: v = int'(b);
        endcase
        return W'(v & ((1 << W) - 1));
    endfunction

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s at %0t: got %02h expected %02h", name, $time, act, exp);
        end
    endtask

    // Monitor: compare outputs with the model, then advance the model by this edge's transfers
    always @(negedge clk) begin
        if (armed) begin
            exp_out = (exp_q.size() > 0) ? exp_q[0] : last_out;
            check("in_ready",  W'(bus.in_ready),  W'(exp_q.size() < 2));
            check("out_valid", W'(bus.out_valid), W'(exp_q.size() > 0));
            check("out",       bus.out,           exp_out);
            check("sel_err",   W'(bus.sel_err),   W'(exp_sel_err));
        end
        if (rst) begin
            exp_q.delete();
            last_out    = '0;
            exp_sel_err = 1'b0;
            armed       = 1'b1;
        end else if (armed) begin
            cons_m = (exp_q.size() > 0) && bus.out_ready;
            acc_m  = bus.in_valid && (exp_q.size() < 2);
            if (cons_m) void'(exp_q.pop_front());
            if (acc_m) begin
                exp_q.push_back(ref_sel(bus.s, bus.B, bus.Im, bus.mem_data));
                if (bus.s >= 3'd5) exp_sel_err = 1'b1;
            end
            if (exp_q.size() > 0) last_out = exp_q[0];
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        if (rand_ready) bus.out_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic idle(input int n);
        bus.in_valid = 1'b0;
        for (int i = 0; i < n; i++) begin
            bus.s        = 3'($urandom);
            bus.B        = W'($urandom);
            bus.Im       = IW'($urandom);
            bus.mem_data = W'($urandom);
            step();
        end
    endtask

    // Present one operand and hold it until the stage takes it
    task automatic send(input logic [2:0] s, input logic [W-1:0] b,
                        input logic [IW-1:0] im, input logic [W-1:0] md);
        bus.in_valid = 1'b1;
        bus.s        = s;
        bus.B        = b;
        bus.Im       = im;
        bus.mem_data = md;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (bus.in_ready) begin
                step();
                bus.in_valid = 1'b0;
                return;
            end
            step();
        end
        compared++;
        mismatched++;
        $display("FAIL send_timeout at %0t: in_ready stuck low, expected acceptance", $time);
        bus.in_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst          = 1'b1;
        bus.in_valid = 1'b1;
        bus.s        = 3'd0;
        bus.B        = 8'h5A;
        bus.Im       = '0;
        bus.mem_data = '0;
        bus.out_ready = 1'b1;

        // 1: reset with in_valid high, then a single accept
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        bus.in_valid = 1'b0;
        idle(1);
        send(3'd0, 8'h5A, 4'h0, 8'h00);
        idle(2);

        // 2: zero/sign extension and constant zero back to back
        send(3'd1, 8'h00, 4'hA, 8'h00);
        send(3'd3, 8'h00, 4'hA, 8'h00);
        send(3'd2, 8'hFF, 4'h0, 8'h00);
        idle(2);

        // 3: backpressure fills both entries, third operand waits upstream
        bus.out_ready = 1'b0;
        send(3'd4, 8'h00, 4'h0, 8'h11);
        send(3'd4, 8'h00, 4'h0, 8'h22);
        fork
            send(3'd4, 8'h00, 4'h0, 8'h33);
            begin
                repeat (4) @(posedge clk);
                #1;
                bus.out_ready = 1'b1;
            end
        join
        idle(3);

        // 4: full throughput
        for (int i = 0; i < 16; i++) send(3'd0, W'(i), 4'h0, 8'h00);
        idle(2);

        // 5: reserved code passes B and latches sel_err
        send(3'd6, 8'h3C, 4'h0, 8'h00);
        send(3'd1, 8'h00, 4'h7, 8'h00);
        send(3'd4, 8'h00, 4'h0, 8'hC3);
        idle(2);

        // 6: reset while full
        bus.out_ready = 1'b0;
        send(3'd0, 8'hAA, 4'h0, 8'h00);
        send(3'd0, 8'hBB, 4'h0, 8'h00);
        rst          = 1'b1;
        bus.in_valid = 1'b1;
        bus.B        = 8'hEE;
        @(posedge clk);
        #1;
        rst           = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        idle(1);
        send(3'd0, 8'h77, 4'h0, 8'h00);
        idle(2);

        // Randomized traffic with random backpressure
        rand_ready = 1'b1;
        for (int n = 0; n < 400; n++) begin
            send(3'($urandom), W'($urandom), IW'($urandom), W'($urandom));
            if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 3)));
        end
        rand_ready    = 1'b0;
        bus.out_ready = 1'b1;
        idle(5);
        check("drained", W'(exp_q.size()), W'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
